pwm_capture: RTL and testbench
==============================

Name: pwm_capture

Overview:
Measures an incoming servo-style PWM signal by counting its high time and period in clk cycles. It sits on the FPGA next to the servo PWM generator and reads back either that generator's output or an external servo command line, for closed-loop checking and display. It reports one measurement per complete period, a range-check flag, and a timeout flag for a dead or stuck line.

Parameters:
W, 20, counter and output width in bits; must satisfy TIMEOUT_CYCLES < 2^W.
TIMEOUT_CYCLES, 960000, cycles without a qualifying edge before the line is declared dead (40 ms at 24 MHz).
MIN_PULSE, 12000, smallest high time in cycles considered in range (0.5 ms at 24 MHz).
MAX_PULSE, 60000, largest high time in cycles considered in range (2.5 ms at 24 MHz).

Ports:
clk  input  1  system clock (24 MHz HSOSC domain).
reset  input  1  synchronous, active-low reset.
pwm_in  input  1  asynchronous PWM line to be measured.
pulse_width  output  W  high time of the last complete period, in cycles.
period  output  W  rising-to-rising time of the last complete period, in cycles.
valid  output  1  one-cycle strobe; pulse_width, period and in_range are updated this cycle.
in_range  output  1  MIN_PULSE <= pulse_width <= MAX_PULSE for the current measurement.
timeout  output  1  sticky dead-line flag.

Behaviour:
- Reset value is taken when reset==0 at a clk edge.
- Reset state: all outputs 0; state IDLE; cnt 0; latched high time 0.
- Reset state of sync flops: sync1, sync2 and the delay flop pwm_d all reset to 1. A line that is high at reset release therefore produces no false rise, and a low line produces a fall that IDLE ignores.
- Input path: 2-flop synchronizer gives pwm_s. pwm_d is pwm_s delayed one cycle.
- Edge detect: rise = pwm_s & ~pwm_d; fall = ~pwm_s & pwm_d. Both are combinational from flops.
- Synchronizer latency cancels because both ends of every measurement use the same path.
- cnt (W bits): set to 1 on the clock edge that ends a rise cycle; otherwise increments. It holds once it reaches TIMEOUT_CYCLES. It never wraps.
- State machine states: IDLE, HIGH, LOW.
- IDLE: rise -> HIGH, cnt<=1. All other inputs are ignored and cnt holds.
- HIGH, fall: hi_lat<=cnt, state -> LOW. cnt keeps counting.
- HIGH, no edge and cnt==TIMEOUT_CYCLES: timeout<=1, state -> IDLE.
- LOW, rise: pulse_width<=hi_lat, period<=cnt, in_range<=range_check(hi_lat), valid<=1 (next cycle only), timeout<=0, cnt<=1, state -> HIGH.
- LOW, no edge and cnt==TIMEOUT_CYCLES: timeout<=1, state -> IDLE.
- Exactness: if pwm_s is high for exactly N cycles and rise-to-rise is P cycles, then pulse_width==N and period==P.
- First measurement: valid is first asserted after one full period following reset or timeout, i.e. at the second detected rise.
- Priority: a detected edge beats timeout in the same cycle.
- Minimum high and low time is 1 synchronized cycle. Sub-cycle glitches that the synchronizer swallows are not measured.
- Outputs hold their values between valid strobes.
- Timeout does not clear pulse_width or period. The timeout flag stays 1 until the next valid or reset.
- Reset mid-pulse aborts the measurement: no valid is produced, and a new measurement starts from IDLE.

Test Plan:
- Reset, then pwm_in with high time 36000 and period 480000 for 3 periods -> valid once per period starting at the 2nd rise; pulse_width=36000, period=480000, in_range=1, timeout=0.
- High time 3600, period 480000 -> pulse_width=3600, in_range=0. Then high time 60000 -> in_range=1. Then 60001 -> in_range=0.
- Hold pwm_in=1 after a rise -> timeout=1 exactly TIMEOUT_CYCLES+1 cycles after the detected rise, no valid. Then a normal waveform -> timeout clears on the next valid.
- Hold pwm_in=1 through reset and release reset -> no valid until a falling edge followed by two rising edges. Holding pwm_in=0 gives the same: no valid until two rises.
- Assert reset mid-high at cycle 20000 of a 36000 pulse -> outputs 0 next cycle, no spurious valid. The next full waveform measures 36000/480000.
- Narrow waveform (bench overrides W=8, TIMEOUT_CYCLES=200): high 1 cycle, period 2 cycles -> pulse_width=1, period=2 on every valid; an edge coinciding with cnt==TIMEOUT_CYCLES produces a measurement, not a timeout.

Source files
------------

// File: rtl/pwm_capture_if.sv
// PWM capture bus: the measured line in, and the per-period measurement out.
interface pwm_capture_if #(
  parameter int unsigned W = 20
);
  logic         pwm_in;
  logic [W-1:0] pulse_width;
  logic [W-1:0] period;
  logic         valid;
  logic         in_range;
  logic         timeout;

  // master: the capture block; slave: whoever drives the line and reads results
  modport master (
    input  pwm_in,
    output pulse_width,
    output period,
    output valid,
    output in_range,
    output timeout
  );

  modport slave (
    output pwm_in,
    input  pulse_width,
    input  period,
    input  valid,
    input  in_range,
    input  timeout
  );
endinterface

// File: rtl/pwm_capture.sv
// Measures high time and rise-to-rise period of an asynchronous servo PWM line
// in clk cycles, with a pulse range check and a sticky dead-line timeout.
module pwm_capture #(
  parameter int unsigned W              = 20,
  parameter int unsigned TIMEOUT_CYCLES = 960000,
  parameter int unsigned MIN_PULSE      = 12000,
  parameter int unsigned MAX_PULSE      = 60000
) (
  input  logic          clk,
  input  logic          reset,
  pwm_capture_if.master cap
);

  localparam logic [W-1:0] CNT_MAX = W'(TIMEOUT_CYCLES);
  localparam logic [W-1:0] LO_LIM  = W'(MIN_PULSE);
  localparam logic [W-1:0] HI_LIM  = W'(MAX_PULSE);
  localparam logic [W-1:0] CNT_ONE = W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  logic         sync1;
  logic         sync2;
  logic         pwm_d;
  logic         pwm_s;
  logic         rise_c;
  logic         fall_c;

  state_t       state;
  state_t       state_n;
  logic [W-1:0] cnt;
  logic [W-1:0] cnt_n;
  logic [W-1:0] hi_lat;
  logic [W-1:0] hi_lat_n;
  logic [W-1:0] pulse_width;
  logic [W-1:0] pulse_width_n;
  logic [W-1:0] period;
  logic [W-1:0] period_n;
  logic         valid;
  logic         valid_n;
  logic         in_range;
  logic         in_range_n;
  logic         timeout;
  logic         timeout_n;

  // Synchronizer and delay flop reset high so a line held high gives no false rise
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      pwm_d <= 1'b1;
    end else begin
      sync1 <= cap.pwm_in;
      sync2 <= sync1;
      pwm_d <= sync2;
    end
  end

  assign pwm_s  = sync2;
  assign rise_c = pwm_s & ~pwm_d;
  assign fall_c = ~pwm_s & pwm_d;

  function automatic logic range_check(input logic [W-1:0] x);
    return (x >= LO_LIM) && (x <= HI_LIM);
  endfunction

  // State and measurement registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      hi_lat      <= '0;
      pulse_width <= '0;
      period      <= '0;
      valid       <= 1'b0;
      in_range    <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      hi_lat      <= hi_lat_n;
      pulse_width <= pulse_width_n;
      period      <= period_n;
      valid       <= valid_n;
      in_range    <= in_range_n;
      timeout     <= timeout_n;
    end
  end

  // Next state; a detected edge always wins over a timeout in the same cycle
  always_comb begin
    state_n       = state;
    cnt_n         = cnt;
    hi_lat_n      = hi_lat;
    pulse_width_n = pulse_width;
    period_n      = period;
    valid_n       = 1'b0;
    in_range_n    = in_range;
    timeout_n     = timeout;

    if ((state != IDLE) && (cnt != CNT_MAX)) begin
      cnt_n = cnt + CNT_ONE;
    end

    case (state)
      IDLE: begin
        cnt_n = cnt;
        if (rise_c) begin
          state_n = HIGH;
          cnt_n   = CNT_ONE;
        end
      end
      HIGH: begin
        if (fall_c) begin
          hi_lat_n = cnt;
          state_n  = LOW;
        end else if (cnt == CNT_MAX) begin
          timeout_n = 1'b1;
          state_n   = IDLE;
        end
      end
      LOW: begin
        if (rise_c) begin
          pulse_width_n = hi_lat;
          period_n      = cnt;
          in_range_n    = range_check(hi_lat);
          valid_n       = 1'b1;
          timeout_n     = 1'b0;
          cnt_n         = CNT_ONE;
          state_n       = HIGH;
        end else if (cnt == CNT_MAX) begin
          timeout_n = 1'b1;
          state_n   = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign cap.pulse_width = pulse_width;
  assign cap.period      = period;
  assign cap.valid       = valid;
  assign cap.in_range    = in_range;
  assign cap.timeout     = timeout;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture with a scaled-down configuration
// (W=8, timeout 200 cycles, in-range window 10..50 cycles).
module tb_pwm_capture;

  localparam int unsigned W  = 8;
  localparam int unsigned TO = 200;

  logic clk = 1'b0;
  logic reset;

  int compared   = 0;
  int mismatched = 0;
  int vcount     = 0;
  int narrow_cnt = 0;

  pwm_capture_if #(.W(W)) bus ();

  pwm_capture #(
    .W              (W),
    .TIMEOUT_CYCLES (TO),
    .MIN_PULSE      (10),
    .MAX_PULSE      (50)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .cap   (bus)
  );

  always #5 clk = ~clk;

  // Strobe monitor: counts valid cycles and the ones carrying a 1/2 measurement
  always @(negedge clk) begin
    if (bus.valid === 1'b1) begin
      vcount <= vcount + 1;
      if (bus.pulse_width == 8'd1 && bus.period == 8'd2)
        narrow_cnt <= narrow_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    #1;
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // One period: pwm_in high for hi cycles then low, per cycles in total
  task automatic wave(input int hi, input int per);
    for (int i = 0; i < per; i++) begin
      @(negedge clk);
      bus.pwm_in = (i < hi);
    end
  endtask

  task automatic hold(input logic level, input int n);
    repeat (n) begin
      @(negedge clk);
      bus.pwm_in = level;
    end
  endtask

  initial begin
    bus.pwm_in = 1'b0;
    reset      = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pw",    32'(bus.pulse_width), 0);
    check("rst_per",   32'(bus.period), 0);
    check("rst_valid", 32'(bus.valid), 0);
    check("rst_inr",   32'(bus.in_range), 0);
    check("rst_to",    32'(bus.timeout), 0);
    reset = 1'b1;

    // Three 15/100 periods: two measurements (2nd and 3rd rise)
    hold(1'b0, 10);
    wave(15, 100); wave(15, 100); wave(15, 100);
    check("basic_cnt", 32'(vcount), 2);
    check("basic_pw",  32'(bus.pulse_width), 15);
    check("basic_per", 32'(bus.period), 100);
    check("basic_inr", 32'(bus.in_range), 1);
    check("basic_to",  32'(bus.timeout), 0);

    // Range checks; each wave's start completes the previous period
    wave(3, 100);
    wave(20, 150);
    check("short_pw",  32'(bus.pulse_width), 3);
    check("short_inr", 32'(bus.in_range), 0);
    wave(50, 100);
    check("p150_pw",   32'(bus.pulse_width), 20);
    check("p150_per",  32'(bus.period), 150);
    wave(51, 100);
    check("max_pw",    32'(bus.pulse_width), 50);
    check("max_inr",   32'(bus.in_range), 1);
    wave(9, 100);
    check("over_pw",   32'(bus.pulse_width), 51);
    check("over_inr",  32'(bus.in_range), 0);
    wave(10, 100);
    check("under_inr", 32'(bus.in_range), 0);
    wave(15, 100);
    check("min_pw",    32'(bus.pulse_width), 10);
    check("min_inr",   32'(bus.in_range), 1);
    check("range_cnt", 32'(vcount), 9);

    // Stuck high: timeout appears TO+1 cycles after the detected rise
    @(negedge clk);
    bus.pwm_in = 1'b1;
    repeat (TO + 2) @(negedge clk);
    check("to_early",  32'(bus.timeout), 0);
    @(negedge clk);
    check("to_set",    32'(bus.timeout), 1);
    check("to_cnt",    32'(vcount), 10);
    check("to_keeppw", 32'(bus.pulse_width), 15);
    check("to_keepper",32'(bus.period), 100);
    hold(1'b1, 5);
    hold(1'b0, 20);
    wave(15, 100);
    check("to_first_rise_cnt", 32'(vcount), 10);
    check("to_sticky", 32'(bus.timeout), 1);
    wave(15, 100);
    check("to_clear",  32'(bus.timeout), 0);
    check("to_rec_cnt", 32'(vcount), 11);

    // Line held high through reset
    @(negedge clk);
    bus.pwm_in = 1'b1;
    reset      = 1'b0;
    repeat (3) @(negedge clk);
    check("rsthi_pw",  32'(bus.pulse_width), 0);
    reset = 1'b1;
    hold(1'b1, 20);
    check("rsthi_cnt0", 32'(vcount), 11);
    hold(1'b0, 20);
    wave(15, 100);
    check("rsthi_cnt1", 32'(vcount), 11);
    wave(15, 100);
    check("rsthi_cnt2", 32'(vcount), 12);
    check("rsthi_per", 32'(bus.period), 100);

    // Line held low through reset
    @(negedge clk);
    bus.pwm_in = 1'b0;
    reset      = 1'b0;
    repeat (3) @(negedge clk);
    check("rstlo_per", 32'(bus.period), 0);
    reset = 1'b1;
    hold(1'b0, 20);
    wave(15, 100);
    check("rstlo_cnt1", 32'(vcount), 12);
    wave(15, 100);
    check("rstlo_cnt2", 32'(vcount), 13);
    check("rstlo_pw",  32'(bus.pulse_width), 15);

    // Reset asserted 8 cycles into a 15-cycle pulse
    @(negedge clk);
    bus.pwm_in = 1'b1;
    repeat (8) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_pw",  32'(bus.pulse_width), 0);
    check("midrst_per", 32'(bus.period), 0);
    check("midrst_to",  32'(bus.timeout), 0);
    reset = 1'b1;
    check("midrst_cnt0", 32'(vcount), 14);
    hold(1'b1, 5);
    hold(1'b0, 85);
    check("midrst_cnt1", 32'(vcount), 14);
    wave(15, 100);
    wave(15, 100);
    check("midrst_cnt2", 32'(vcount), 15);
    check("midrst_pw2",  32'(bus.pulse_width), 15);
    check("midrst_per2", 32'(bus.period), 100);

    // Narrowest waveform: 1 high, 1 low
    for (int k = 0; k < 10; k++) wave(1, 2);
    hold(1'b0, 4);
    check("narrow_cnt", 32'(vcount), 25);
    check("narrow_ok",  32'(narrow_cnt), 9);
    check("narrow_pw",  32'(bus.pulse_width), 1);
    check("narrow_per", 32'(bus.period), 2);

    // Rise exactly at cnt==TO measures; one cycle later it times out
    wave(15, 200);
    wave(15, 100);
    check("edge_to_per", 32'(bus.period), 200);
    check("edge_to_to",  32'(bus.timeout), 0);
    check("edge_to_cnt", 32'(vcount), 27);
    wave(15, 201);
    wave(15, 100);
    check("late_to",     32'(bus.timeout), 1);
    check("late_cnt",    32'(vcount), 28);
    check("late_per",    32'(bus.period), 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
